// File: rtl/pipeadd_pkg.sv
// Shared definitions for the pipelined adder: operand geometry, group tag width
// and the input loader state encoding.
package pipeadd_pkg;

   localparam int LANES  = 8;
   localparam int DATA_W = 8;
   localparam int TAG_W  = 4;

   typedef enum logic {
      COLLECT = 1'b0,
      FULL    = 1'b1
   } loader_state_t;

   // Group sequence numbers are modulo 2**TAG_W so they wrap 15 -> 0.
   function automatic logic [TAG_W-1:0] tag_next(input logic [TAG_W-1:0] tag);
      return tag + 1'b1;
   endfunction

endpackage

// File: rtl/tree_input_loader_if.sv
// Serial byte input and parallel group output of the tree input loader.
// The flush input exists only when LOADER_FLUSH_EN is defined.
interface tree_input_loader_if #(
   parameter int DATA_W = pipeadd_pkg::DATA_W,
   parameter int LANES  = pipeadd_pkg::LANES,
   parameter int TAG_W  = pipeadd_pkg::TAG_W
) ();

   logic [DATA_W-1:0]       in_data;
   logic                    in_valid;
   logic                    in_ready;
   logic [LANES*DATA_W-1:0] out_lanes;
   logic                    out_valid;
   logic                    out_ready;
   logic [TAG_W-1:0]        out_tag;

`ifdef LOADER_FLUSH_EN
   logic                    flush;

   // master: byte producer plus adder-tree consumer; slave: the loader itself
   modport master (
      output in_data, in_valid, out_ready, flush,
      input  in_ready, out_lanes, out_valid, out_tag
   );

   modport slave (
      input  in_data, in_valid, out_ready, flush,
      output in_ready, out_lanes, out_valid, out_tag
   );
`else
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_lanes, out_valid, out_tag
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_lanes, out_valid, out_tag
   );
`endif

endinterface

// File: rtl/loader_out_reg.sv
// Output holding register of the tree input loader: one operand group plus its
// sequence tag, released to the adder tree with a valid/ready handshake.
module loader_out_reg #(
   parameter int DATA_W = pipeadd_pkg::DATA_W,
   parameter int LANES  = pipeadd_pkg::LANES,
   parameter int TAG_W  = pipeadd_pkg::TAG_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [LANES*DATA_W-1:0] load_lanes,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] out_lanes,
   output logic                    out_valid,
   output logic [TAG_W-1:0]        out_tag,
   output logic                    free
);
   import pipeadd_pkg::*;

   logic [TAG_W-1:0] seq_q;

   // A load may land in the same cycle the current group is consumed.
   assign free = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_lanes <= '0;
         out_tag   <= '0;
         seq_q     <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_lanes <= load_lanes;
         out_tag   <= seq_q;
         seq_q     <= tag_next(seq_q);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/tree_input_loader.sv
// Collects serial operand bytes into groups of LANES and hands each group to
// the adder tree. Defining LOADER_FLUSH_EN adds a flush that zero-pads a partial group.
module tree_input_loader #(
   parameter int DATA_W = pipeadd_pkg::DATA_W,
   parameter int LANES  = pipeadd_pkg::LANES
) (
   input logic                clk,
   input logic                rst,
   tree_input_loader_if.slave bus
);
   import pipeadd_pkg::*;

   localparam int CNT_W = $clog2(LANES);

   typedef logic [LANES-1:0][DATA_W-1:0] group_t;

   loader_state_t    state;
   logic [CNT_W-1:0] cnt;
   group_t           collect_q;
   group_t           group_next;
   group_t           load_lanes;
   logic             accept;
   logic             last_byte;
   logic             flush_now;
   logic             group_done;
   logic             out_free;
   logic             load_out;

   assign bus.in_ready = !rst && (state == COLLECT);
   assign accept       = bus.in_valid && bus.in_ready;
   assign last_byte    = accept && (cnt == CNT_W'(LANES - 1));

`ifdef LOADER_FLUSH_EN
   assign flush_now = bus.flush && !rst && (state == COLLECT) && ((cnt != '0) || accept);
`else
   assign flush_now = 1'b0;
`endif

   assign group_done = last_byte || flush_now;

   // Collect buffer as it will look after this cycle; flush padding starts
   // just above the byte accepted in the same cycle, if any.
   always_comb begin
      group_next = collect_q;
      for (int i = 0; i < LANES; i++) begin
         if (accept && (i == int'(cnt)))
            group_next[i] = bus.in_data;
         else if (flush_now && (i >= int'(cnt)))
            group_next[i] = '0;
      end
   end

   // A completed group skips FULL when the output register can take it at
   // once, which keeps streaming at one byte per cycle with no bubbles.
   assign load_out   = out_free && ((state == FULL) || group_done);
   assign load_lanes = (state == FULL) ? collect_q : group_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= COLLECT;
         cnt       <= '0;
         collect_q <= '0;
      end else begin
         case (state)
            COLLECT: begin
               if (accept || flush_now)
                  collect_q <= group_next;
               if (group_done) begin
                  cnt <= '0;
                  if (!out_free)
                     state <= FULL;
               end else if (accept) begin
                  cnt <= cnt + 1'b1;
               end
            end
            FULL: begin
               if (out_free)
                  state <= COLLECT;
            end
            default: state <= COLLECT;
         endcase
      end
   end

   loader_out_reg #(
      .DATA_W(DATA_W),
      .LANES (LANES),
      .TAG_W (TAG_W)
   ) u_out_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (load_out),
      .load_lanes(load_lanes),
      .out_ready (bus.out_ready),
      .out_lanes (bus.out_lanes),
      .out_valid (bus.out_valid),
      .out_tag   (bus.out_tag),
      .free      (out_free)
   );

endmodule

// File: doc/tree_input_loader.md
TREE_INPUT_LOADER -- requirements
Module: tree_input_loader

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of each operand byte and of each output lane.
REQ-002 Parameter LANES, default 8, SHALL set the number of operands per group; only the value 8 is supported.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 in_data  input  DATA_W  SHALL carry the serial operand.
REQ-006 in_valid  input  1  SHALL indicate that in_data is valid.
REQ-007 in_ready  output  1  SHALL indicate that the loader accepts a byte this cycle.
REQ-008 out_lanes  output  LANES*DATA_W  SHALL carry the operand group, with lane 0 in bits [DATA_W-1:0].
REQ-009 out_valid  output  1  SHALL indicate that out_lanes holds a complete group.
REQ-010 out_ready  input  1  SHALL indicate that the adder tree takes the group this cycle.
REQ-011 out_tag  output  4  SHALL carry the group sequence number, for alignment with the tree output.
REQ-012 flush  input  1  SHALL be present only when LOADER_FLUSH_EN is defined.

Function
REQ-013 A byte SHALL be accepted on any cycle with in_valid=1 and in_ready=1; the byte SHALL be written to collect lane cnt, and cnt (0..7) SHALL then increment.
REQ-014 Byte accept order SHALL map to lanes 0..7: the first byte goes to lane 0 and the eighth to lane 7.
REQ-015 The block SHALL have two states, COLLECT and FULL.
- In COLLECT, in_ready SHALL be 1.
- Accepting the byte at cnt=7 SHALL move the state to FULL and wrap cnt to 0.
REQ-016 Group transfer: a group in FULL SHALL move to the output register when the output register is empty or is being consumed in the same cycle (out_valid & out_ready); the state SHALL then return to COLLECT.
REQ-017 The transfer SHALL take 1 cycle: out_valid SHALL rise in the cycle after the eighth byte is accepted when the output register is free.
REQ-018 In FULL with the output register occupied and out_ready=0, in_ready SHALL be 0; no byte SHALL be lost or overwritten.
REQ-019 Sustained throughput with out_ready held at 1 SHALL be 1 byte per cycle, with no bubbles between groups.
REQ-020 A group SHALL be consumed on out_valid & out_ready; out_valid SHALL drop the next cycle unless a new group is transferred in the same cycle.
REQ-021 out_lanes and out_tag SHALL be held stable while out_valid=1 and out_ready=0.
REQ-022 out_tag SHALL increment by 1 on every transfer into the output register and SHALL wrap from 15 to 0.
REQ-023 Data SHALL pass through unmodified; no arithmetic SHALL be applied. Widths SHALL be exact (DATA_W in, DATA_W per lane).

Reset
REQ-024 While rst=1 at a clock edge, the block SHALL set state=COLLECT, cnt=0, out_valid=0, out_tag=0, out_lanes=0 and collect lanes=0.
REQ-025 During reset, in_ready SHALL be 0; it SHALL go to 1 in the first cycle after rst deasserts.
REQ-026 Reset mid-group SHALL discard the partial group and any held output group; no out_valid SHALL follow from pre-reset data.

Configuration
REQ-027 With LOADER_FLUSH_EN defined, flush=1 in COLLECT with cnt>0 SHALL zero-fill lanes cnt..7 and enter FULL in that cycle; a byte accepted in the same cycle SHALL be included before the padding.
REQ-028 With LOADER_FLUSH_EN defined, flush with cnt=0 and no byte accepted, or flush in FULL, SHALL have no effect.
REQ-029 Without LOADER_FLUSH_EN, the flush port and its logic SHALL be absent; a partial group SHALL wait indefinitely for more bytes.

Structure
REQ-030 Shared package pipeadd_pkg SHALL hold LANES, DATA_W, the tag width (4) and the loader state enum {COLLECT, FULL}; the adder stages SHALL import the same LANES and DATA_W.
REQ-031 The output holding register (valid/ready register slice with tag) SHALL be the sub-module loader_out_reg. The collect buffer, counter and FSM SHALL stay in the top module.

Verification
REQ-032 The bench SHALL cover:
- Reset, then bytes 1..8 on consecutive cycles with out_ready=1 -> out_valid=1 one cycle after byte 8; lanes 0..7 = 1..8; out_tag=0.
- 16 bytes back-to-back with out_ready=1 -> two groups on cycles 9 and 17; tags 0 and 1; in_ready never 0.
- out_ready=0, 16 bytes offered -> first group held stable; in_ready=0 after byte 16; out_ready=1 for 1 cycle -> second group, tag 1, appears the next cycle and in_ready returns to 1.
- 3 bytes 0xAA, 0xBB, 0xCC, then rst=1 for 1 cycle, then bytes 1..8 -> exactly one group, lanes 1..8, tag 0.
- LOADER_FLUSH_EN: bytes 5, 6, 7 then flush -> lanes = {5,6,7,0,0,0,0,0}; a subsequent byte lands in lane 0 of the next group.
- 17 groups streamed -> out_tag sequence 0..15 then 0.
